risc8_pipeline_core: RTL and testbench
======================================

Name: risc8_pipeline_core

Overview:
- 8-bit, 5-stage (IF/ID/EX/MEM/WB) pipelined RISC core. The program is held in an internal hard-coded ROM.
- Executes a fixed self-test program after reset, then halts and freezes all architectural state.
- Used as a standalone self-checking top; benches inspect internal state hierarchically.

Parameters:
- PC_W, 4, program counter width (16-entry instruction ROM).
- DATA_W, 8, datapath and register width (fixed; not to be overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- halted  output  1  high once HALT retires; sticky until reset.

Behaviour:
- Required internal names, for hierarchical checking:
  - reg_file[0:7]: 8x8-bit register file. R0 reads 0 and writes to it are ignored.
  - data_mem_loc_12: 8-bit register, the only data-memory location.
  - halted: the port above.
- Reset (rst=0, async): PC=0; all pipeline registers become NOPs; reg_file all 0; data_mem_loc_12=0; halted=0.
- Instruction format (16 bits): opcode[15:12], A[11:9], B[8:6], C[5:3], imm6[5:0], imm8[7:0].
- Opcodes:
  - 0 NOP.
  - 1 ADD: R[A] = R[B] + R[C], mod 256.
  - 2 SUB: R[A] = R[B] - R[C], mod 256 (wraps).
  - 3 LI: R[A] = imm8.
  - 4 LW: R[A] = mem[R[B] + imm6].
  - 5 SW: mem[R[B] + imm6] = R[A].
  - 6 BEQ: if R[A] == R[B], PC = imm6 (absolute).
  - F HALT.
  - Any other opcode executes as NOP.
- Memory:
  - Address = 8-bit sum, wrapping.
  - SW to address 12 updates data_mem_loc_12; SW to any other address is ignored.
  - LW from address 12 returns data_mem_loc_12; LW from any other address returns 0.
- Register file: WB writes on the clock edge. An ID read of the register being written in the same cycle returns the new value (internal bypass).
- Forwarding: the EX operand takes EX/MEM first, then MEM/WB, then the ID value. Only ALU/LI results are forwarded from EX/MEM.
- Load-use hazard: an instruction in ID that uses the rd of an LW in EX stalls one cycle. PC and IF/ID hold; a bubble is inserted into EX.
- BEQ:
  - Resolved in EX.
  - If taken: PC loads the target next cycle, and the IF/ID and ID/EX contents are flushed to NOP (2-cycle penalty).
  - If not taken: no penalty.
- HALT:
  - On decode, PC stops advancing; younger fetches become NOPs.
  - When HALT reaches WB, halted=1.
  - Afterwards no register or memory writes occur.
- Hard-coded ROM program:
  - 0: LI R1,5
  - 1: LI R2,10
  - 2: ADD R3,R1,R2
  - 3: LI R4,12
  - 4: SW R3,0(R4)
  - 5: LW R5,0(R4)
  - 6: SUB R6,R2,R1
  - 7: BEQ R1,R6,10
  - 8: LI R7,0xFF
  - 9: LI R7,0xFF
  - 10: HALT
  - 11-15: NOP
- Final state after the program: R1=5, R2=10, R3=15, R4=12, R5=15, R6=5, R7=0, data_mem_loc_12=15.
- halted must rise within 30 cycles of reset release.
- Reset mid-run: state returns immediately to reset values, and the program restarts from PC 0 on release.

Test Plan:
- Hold rst=0 for 2 cycles -> halted=0, all reg_file=0, data_mem_loc_12=0, PC=0.
- Release reset and wait for halted (timeout 200 cycles) -> halted=1 within 30 cycles; R1=5, R2=10, R3=15, R4=12.
- After halt, check the memory path -> data_mem_loc_12=15 (SW with base forwarded from the LI directly before it); R5=15 (LW directly after SW).
- After halt, check the branch path -> R6=5, and R7=0, proving the taken BEQ flushed instructions 8 and 9.
- After halt, run 20 more cycles -> all registers and data_mem_loc_12 unchanged; halted stays 1.
- Assert rst=0 mid-program (cycle 6), then release -> state clears; the rerun reaches the same final values and halts again.

Source files
------------

// File: rtl/risc8_pipeline_core.sv
// risc8_pipeline_core: 5-stage 8-bit RISC core running a fixed self-test program from ROM, then halting.
// Forwards from EX/MEM and MEM/WB, stalls once on load-use, and resolves BEQ in EX with a two-slot flush.
module risc8_pipeline_core #(
  parameter int PC_W   = 4,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst,
  output logic halted
);
  localparam logic [3:0] OP_ADD = 4'd1, OP_SUB = 4'd2, OP_LI = 4'd3, OP_LW = 4'd4,
                         OP_SW = 4'd5, OP_BEQ = 4'd6, OP_HALT = 4'd15;
  localparam logic [15:0] ROM [0:15] = '{
    16'h3205, 16'h340A, 16'h1650, 16'h380C, 16'h5700, 16'h4B00, 16'h2C88, 16'h638A,
    16'h3EFF, 16'h3EFF, 16'hF000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

  function automatic logic [2:0] src1(input logic [15:0] ir);
    return ir[15:12] == OP_BEQ ? ir[11:9] : ir[8:6];
  endfunction
  function automatic logic [2:0] src2(input logic [15:0] ir);
    return ir[15:12] == OP_SW ? ir[11:9] : ir[15:12] == OP_BEQ ? ir[8:6] : ir[5:3];
  endfunction

  logic [PC_W-1:0]   pc;
  logic [15:0]       if_id_ir, id_ex_ir;
  logic [DATA_W-1:0] id_ex_v1, id_ex_v2;
  logic [3:0]        ex_mem_op, mem_wb_op;
  logic [2:0]        ex_mem_rd, mem_wb_rd;
  logic [DATA_W-1:0] ex_mem_res, ex_mem_sd, mem_wb_val;
  logic [DATA_W-1:0] reg_file [0:7];
  logic [DATA_W-1:0] data_mem_loc_12;
  logic              halt_seen;

  logic [3:0]        d_op, e_op;
  logic [2:0]        d_s1, d_s2, e_s1, e_s2, e_rd;
  logic              d_u1, d_u2, wb_we, exm_fw, stall, taken, fetch_stop;
  logic [DATA_W-1:0] rd1, rd2, f1, f2, alu, load;

  assign d_op  = if_id_ir[15:12];
  assign d_s1  = src1(if_id_ir);
  assign d_s2  = src2(if_id_ir);
  assign d_u1  = d_op inside {OP_ADD, OP_SUB, OP_LW, OP_SW, OP_BEQ};
  assign d_u2  = d_op inside {OP_ADD, OP_SUB, OP_SW, OP_BEQ};
  assign wb_we = mem_wb_op inside {OP_ADD, OP_SUB, OP_LI, OP_LW} && mem_wb_rd != 3'd0 && !halted;
  // Same-cycle WB write is visible to the ID read
  assign rd1   = (wb_we && mem_wb_rd == d_s1) ? mem_wb_val : reg_file[d_s1];
  assign rd2   = (wb_we && mem_wb_rd == d_s2) ? mem_wb_val : reg_file[d_s2];
  assign stall = id_ex_ir[15:12] == OP_LW && id_ex_ir[11:9] != 3'd0 &&
                 ((d_u1 && d_s1 == id_ex_ir[11:9]) || (d_u2 && d_s2 == id_ex_ir[11:9]));

  assign e_op   = id_ex_ir[15:12];
  assign e_rd   = id_ex_ir[11:9];
  assign e_s1   = src1(id_ex_ir);
  assign e_s2   = src2(id_ex_ir);
  assign exm_fw = ex_mem_op inside {OP_ADD, OP_SUB, OP_LI} && ex_mem_rd != 3'd0;
  assign f1 = (exm_fw && ex_mem_rd == e_s1) ? ex_mem_res : (wb_we && mem_wb_rd == e_s1) ? mem_wb_val : id_ex_v1;
  assign f2 = (exm_fw && ex_mem_rd == e_s2) ? ex_mem_res : (wb_we && mem_wb_rd == e_s2) ? mem_wb_val : id_ex_v2;
  assign alu = e_op == OP_ADD ? f1 + f2 :
               e_op == OP_SUB ? f1 - f2 :
               e_op == OP_LI  ? id_ex_ir[7:0] : f1 + {2'b00, id_ex_ir[5:0]};
  assign taken      = e_op == OP_BEQ && f1 == f2;
  assign fetch_stop = halt_seen || (d_op == OP_HALT && !taken);
  assign load       = ex_mem_res == 8'd12 ? data_mem_loc_12 : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc              <= '0;
      if_id_ir        <= '0;
      id_ex_ir        <= '0;
      id_ex_v1        <= '0;
      id_ex_v2        <= '0;
      ex_mem_op       <= '0;
      ex_mem_rd       <= '0;
      ex_mem_res      <= '0;
      ex_mem_sd       <= '0;
      mem_wb_op       <= '0;
      mem_wb_rd       <= '0;
      mem_wb_val      <= '0;
      data_mem_loc_12 <= '0;
      halt_seen       <= 1'b0;
      halted          <= 1'b0;
    end else begin
      if (taken) begin
        pc       <= id_ex_ir[PC_W-1:0];
        if_id_ir <= '0;
        id_ex_ir <= '0;
      end else if (stall) begin
        id_ex_ir <= '0;
      end else begin
        pc        <= fetch_stop ? pc : pc + PC_W'(1);
        if_id_ir  <= fetch_stop ? 16'h0000 : ROM[pc];
        id_ex_ir  <= if_id_ir;
        id_ex_v1  <= rd1;
        id_ex_v2  <= rd2;
        halt_seen <= halt_seen || d_op == OP_HALT;
      end
      ex_mem_op  <= e_op;
      ex_mem_rd  <= e_rd;
      ex_mem_res <= alu;
      ex_mem_sd  <= f2;
      mem_wb_op  <= ex_mem_op;
      mem_wb_rd  <= ex_mem_rd;
      mem_wb_val <= ex_mem_op == OP_LW ? load : ex_mem_res;
      if (mem_wb_op == OP_HALT) halted <= 1'b1;
      if (!halted && ex_mem_op == OP_SW && ex_mem_res == 8'd12) data_mem_loc_12 <= ex_mem_sd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) reg_file[i] <= '0;
    end else if (wb_we) begin
      reg_file[mem_wb_rd] <= mem_wb_val;
    end
  end
endmodule

// File: tb/tb_risc8_pipeline_core.sv
// tb_risc8_pipeline_core: directed checks of reset, program results, post-halt freeze and mid-run reset.
module tb_risc8_pipeline_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic halted;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc;
  int   exp_r [0:7] = '{0, 5, 10, 15, 12, 15, 5, 0};

  risc8_pipeline_core dut (.clk(clk), .rst(rst), .halted(halted));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_final(input string pfx);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_r%0d", pfx, i), int'(dut.reg_file[i]), exp_r[i]);
    chk({pfx, "_mem12"}, int'(dut.data_mem_loc_12), 15);
    chk({pfx, "_halted"}, int'(halted), 1);
  endtask

  task automatic chk_reset(input string pfx);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_r%0d", pfx, i), int'(dut.reg_file[i]), 0);
    chk({pfx, "_mem12"}, int'(dut.data_mem_loc_12), 0);
    chk({pfx, "_halted"}, int'(halted), 0);
    chk({pfx, "_pc"}, int'(dut.pc), 0);
  endtask

  task automatic run_to_halt(input string pfx);
    cyc = 0;
    while (halted !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk({pfx, "_halt_within_30"}, int'(cyc <= 30 && halted === 1'b1), 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst = 1'b1;
    run_to_halt("run1");
    chk_final("run1");
    repeat (20) @(negedge clk);
    chk_final("frozen");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("rst2");
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_r1", int'(dut.reg_file[1]), 5);
    chk("mid_halted", int'(halted), 0);
    rst = 1'b0;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_to_halt("run2");
    chk_final("run2");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
